// File: rtl/ram_arb_pkg.sv
// Shared types for the single-port SRAM arbiter: response owner tag, muxed
// memory request and the stall-counter width used by the optional perf block.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INSTR,
        OWN_DATA,
        OWN_BOOT
    } owner_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam int PERF_W = 16;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester (boot/instr/data) and SRAM-side signals of the arbiter, bundled so
// the core, bootloader and macro hookups are a single connection.
interface ram_arbiter_if #(
    parameter int AW = 10
);
    logic          boot_req;
    logic [31:0]   boot_addr;
    logic [31:0]   boot_wdata;
    logic          boot_gnt;

    logic          instr_req;
    logic [31:0]   instr_addr;
    logic          instr_gnt;
    logic          instr_rvalid;
    logic [31:0]   instr_rdata;
    logic          instr_err;

    logic          data_req;
    logic          data_we;
    logic [3:0]    data_be;
    logic [31:0]   data_addr;
    logic [31:0]   data_wdata;
    logic          data_gnt;
    logic          data_rvalid;
    logic [31:0]   data_rdata;
    logic          data_err;

    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // Arbiter view.
    modport slave (
        input  boot_req, boot_addr, boot_wdata,
        output boot_gnt,
        input  instr_req, instr_addr,
        output instr_gnt, instr_rvalid, instr_rdata, instr_err,
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters plus SRAM macro view.
    modport master (
        output boot_req, boot_addr, boot_wdata,
        input  boot_gnt,
        output instr_req, instr_addr,
        input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker; after a grant to one side the other side is
// favoured. A lone requester always wins.
module rr_arb2 (
    input  logic       clk_sys,
    input  logic       rst_sys_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q;  // 0 favours req[0], 1 favours req[1]

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
            ptr_q <= grant[0];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port SRAM among boot writes, instruction fetch and data.
// Optional stall counters are built when RAM_ARB_PERF_EN is defined.
//
// owner_q   | meaning
// OWN_NONE  | no response due this cycle
// OWN_INSTR | instr_rvalid this cycle
// OWN_DATA  | data_rvalid this cycle
// OWN_BOOT  | boot write in flight, no response returned
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int          MEM_SIZE  = 4096,
    parameter int          AW        = $clog2(MEM_SIZE / 4),
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic              clk_sys,
    input  logic              rst_sys_n,
    ram_arbiter_if.slave      bus
`ifdef RAM_ARB_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [PERF_W-1:0] perf_instr_stall,
    output logic [PERF_W-1:0] perf_data_stall
`endif
);

    logic [31:0] boot_off;
    logic [31:0] instr_off;
    logic [31:0] data_off;
    logic        boot_win;
    logic        instr_win;
    logic        data_win;
    logic [1:0]  rr_req;
    logic [1:0]  rr_gnt;
    mem_req_t    sel;
    logic        in_range;
    owner_t      owner_d;
    owner_t      owner_q;
    logic        err_d;
    logic        err_q;
    logic        zero_d;
    logic        zero_q;
    logic [31:0] instr_hold_q;
    logic [31:0] data_hold_q;

    assign boot_off  = bus.boot_addr  - ADDR_BASE;
    assign instr_off = bus.instr_addr - ADDR_BASE;
    assign data_off  = bus.data_addr  - ADDR_BASE;

    // Gating with rst_sys_n keeps every strobe low while the block is held in reset.
    assign boot_win = rst_sys_n & bus.boot_req;
    assign rr_req   = {bus.data_req, bus.instr_req} & {2{rst_sys_n & ~bus.boot_req}};

    rr_arb2 u_rr_arb2 (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .req       (rr_req),
        .advance   (|rr_gnt),
        .grant     (rr_gnt)
    );

    assign instr_win = rr_gnt[0];
    assign data_win  = rr_gnt[1];

    always_comb begin
        sel      = '0;
        owner_d  = OWN_NONE;
        in_range = 1'b0;
        err_d    = 1'b0;
        zero_d   = 1'b0;
        if (boot_win) begin
            sel     = '{we: 1'b1, be: 4'hf, addr: boot_off, wdata: bus.boot_wdata};
            owner_d = OWN_BOOT;
        end else if (instr_win) begin
            sel     = '{we: 1'b0, be: 4'hf, addr: instr_off, wdata: 32'h0};
            owner_d = OWN_INSTR;
        end else if (data_win) begin
            sel     = '{we: bus.data_we, be: bus.data_be, addr: data_off, wdata: bus.data_wdata};
            owner_d = OWN_DATA;
        end
        in_range = sel.addr < 32'(MEM_SIZE);
        err_d    = (owner_d != OWN_NONE) && !in_range;
        // Writes and errored accesses return zero instead of the SRAM read port.
        zero_d   = !in_range || sel.we;
    end

    assign bus.boot_gnt  = boot_win;
    assign bus.instr_gnt = instr_win;
    assign bus.data_gnt  = data_win;

    assign bus.mem_req   = (owner_d != OWN_NONE) && in_range;
    assign bus.mem_we    = sel.we;
    assign bus.mem_be    = sel.be;
    assign bus.mem_addr  = sel.addr[AW+1:2];
    assign bus.mem_wdata = sel.wdata;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.instr_rvalid = (owner_q == OWN_INSTR);
    assign bus.data_rvalid  = (owner_q == OWN_DATA);
    assign bus.instr_err    = bus.instr_rvalid & err_q;
    assign bus.data_err     = bus.data_rvalid & err_q;

    assign bus.instr_rdata = bus.instr_rvalid ? (zero_q ? 32'h0 : bus.mem_rdata) : instr_hold_q;
    assign bus.data_rdata  = bus.data_rvalid  ? (zero_q ? 32'h0 : bus.mem_rdata) : data_hold_q;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            instr_hold_q <= 32'h0;
            data_hold_q  <= 32'h0;
        end else begin
            if (bus.instr_rvalid) instr_hold_q <= bus.instr_rdata;
            if (bus.data_rvalid)  data_hold_q  <= bus.data_rdata;
        end
    end

`ifdef RAM_ARB_PERF_EN
    logic [PERF_W-1:0] instr_stall_q;
    logic [PERF_W-1:0] data_stall_q;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            instr_stall_q <= '0;
            data_stall_q  <= '0;
        end else if (perf_clr) begin
            instr_stall_q <= '0;
            data_stall_q  <= '0;
        end else begin
            if (bus.instr_req && !instr_win) instr_stall_q <= sat_inc(instr_stall_q);
            if (bus.data_req && !data_win)   data_stall_q  <= sat_inc(data_stall_q);
        end
    end

    assign perf_instr_stall = instr_stall_q;
    assign perf_data_stall  = data_stall_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with a response scoreboard and a
// behavioural SRAM attached to the memory side.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW       = 10;
    localparam int MEM_SIZE = 4096;

    typedef struct {
        logic        is_data;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } resp_t;

    logic  clk_sys   = 1'b0;
    logic  rst_sys_n = 1'b0;
    int    cyc       = 0;
    int    total     = 0;
    int    bad       = 0;
    resp_t exp_q[$];
    logic [31:0] sram [0:(1<<AW)-1];

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc++;

    ram_arbiter_if #(.AW(AW)) bus ();

`ifdef RAM_ARB_PERF_EN
    logic              perf_clr = 1'b0;
    logic [PERF_W-1:0] perf_instr_stall;
    logic [PERF_W-1:0] perf_data_stall;
`endif

    ram_arbiter #(
        .MEM_SIZE  (MEM_SIZE),
        .AW        (AW),
        .ADDR_BASE (32'h0000_0000)
    ) dut (
        .clk_sys          (clk_sys),
        .rst_sys_n        (rst_sys_n),
        .bus              (bus)
`ifdef RAM_ARB_PERF_EN
        ,
        .perf_clr         (perf_clr),
        .perf_instr_stall (perf_instr_stall),
        .perf_data_stall  (perf_data_stall)
`endif
    );

    // Behavioural SRAM: byte-enabled writes, one-cycle read latency.
    always @(posedge clk_sys) begin
        if (bus.mem_req) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= sram[bus.mem_addr];
            end
        end
    end

    // Scoreboard: every rvalid must match the oldest expected response in port, cycle, err and rdata.
    always @(negedge clk_sys) begin : monitor
        resp_t       e;
        logic [33:0] got;
        if (bus.instr_rvalid || bus.data_rvalid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rvalid cycle=%0d instr_rvalid=%0b data_rvalid=%0b required=none",
                         cyc, bus.instr_rvalid, bus.data_rvalid);
            end else begin
                e   = exp_q.pop_front();
                got = e.is_data ? {bus.data_rvalid, bus.data_err, bus.data_rdata}
                                : {bus.instr_rvalid, bus.instr_err, bus.instr_rdata};
                if (got !== {1'b1, e.err, e.rdata} || e.due != cyc || (bus.instr_rvalid && bus.data_rvalid)) begin
                    bad++;
                    $display("FAIL resp_%s cycle=%0d got rvalid/err/rdata=%0b/%0b/%h other_rvalid=%0b required 1/%0b/%h at cycle %0d",
                             e.is_data ? "data" : "instr", cyc, got[33], got[32], got[31:0],
                             e.is_data ? bus.instr_rvalid : bus.data_rvalid, e.err, e.rdata, e.due);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_rvalid_%s cycle=%0d got rvalid=0 required rvalid=1 at cycle %0d",
                     e.is_data ? "data" : "instr", cyc, e.due);
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle();
        bus.boot_req   = 1'b0;
        bus.boot_addr  = 32'h0;
        bus.boot_wdata = 32'h0;
        bus.instr_req  = 1'b0;
        bus.instr_addr = 32'h0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_be    = 4'h0;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
    endtask

    task automatic expect_resp(input logic is_data, input logic err, input logic [31:0] rdata);
        exp_q.push_back('{is_data: is_data, err: err, rdata: rdata, due: cyc + 1});
    endtask

    task automatic test_reset();
        idle();
        rst_sys_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        bus.boot_req  = 1'b1;
        bus.instr_req = 1'b1;
        bus.data_req  = 1'b1;
        @(negedge clk_sys);
        total++;
        if ({bus.boot_gnt, bus.instr_gnt, bus.data_gnt, bus.instr_rvalid, bus.data_rvalid,
             bus.instr_err, bus.data_err, bus.mem_req} !== 8'h0 || bus.instr_rdata !== 32'h0 || bus.data_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got gnt=%b%b%b rvalid=%b%b err=%b%b mem_req=%b rdata=%h/%h required all 0",
                     bus.boot_gnt, bus.instr_gnt, bus.data_gnt, bus.instr_rvalid, bus.data_rvalid,
                     bus.instr_err, bus.data_err, bus.mem_req, bus.instr_rdata, bus.data_rdata);
        end
        idle();
        #2 rst_sys_n = 1'b1;
        step();
    endtask

    task automatic test_boot_priority();
        bus.boot_req   = 1'b1;
        bus.boot_addr  = 32'h20;
        bus.boot_wdata = 32'h1234_5678;
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b0;
        bus.data_be    = 4'hf;
        bus.data_addr  = 32'h20;
        @(negedge clk_sys);
        total++;
        if ({bus.boot_gnt, bus.data_gnt, bus.mem_req, bus.mem_we, bus.mem_be} !== 8'b1011_1111 ||
            bus.mem_addr !== 10'd8 || bus.mem_wdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL boot_priority got boot_gnt=%b data_gnt=%b mem_req=%b we=%b be=%h addr=%0d wdata=%h required 1 0 1 1 f 8 12345678",
                     bus.boot_gnt, bus.data_gnt, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
        end
        step();
        bus.boot_req = 1'b0;
        @(negedge clk_sys);
        total++;
        if ({bus.boot_gnt, bus.data_gnt, bus.mem_req, bus.mem_we} !== 4'b0110 || bus.mem_addr !== 10'd8) begin
            bad++;
            $display("FAIL data_after_boot got boot_gnt=%b data_gnt=%b mem_req=%b we=%b addr=%0d required 0 1 1 0 8",
                     bus.boot_gnt, bus.data_gnt, bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        expect_resp(1'b1, 1'b0, 32'h1234_5678);
        step();
        idle();
        bus.boot_req   = 1'b1;
        bus.boot_addr  = 32'h10;
        bus.boot_wdata = 32'hDEAD_BEEF;
        @(negedge clk_sys);
        total++;
        if ({bus.boot_gnt, bus.mem_req, bus.mem_we} !== 3'b111 || bus.mem_addr !== 10'd4) begin
            bad++;
            $display("FAIL boot_write got boot_gnt=%b mem_req=%b we=%b addr=%0d required 1 1 1 4",
                     bus.boot_gnt, bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        step();
        idle();
    endtask

    task automatic test_instr_read();
        bus.instr_req  = 1'b1;
        bus.instr_addr = 32'h10;
        @(negedge clk_sys);
        total++;
        if ({bus.instr_gnt, bus.data_gnt, bus.mem_req, bus.mem_we} !== 4'b1010 || bus.mem_addr !== 10'd4) begin
            bad++;
            $display("FAIL instr_read_grant got gnt=%b mem_req=%b we=%b addr=%0d required 1 1 0 4",
                     bus.instr_gnt, bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        expect_resp(1'b0, 1'b0, 32'hDEAD_BEEF);
        step();
        idle();
        step();
        @(negedge clk_sys);
        total++;
        if (bus.instr_rvalid !== 1'b0 || bus.instr_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL instr_rdata_hold got rvalid=%b rdata=%h required 0 deadbeef", bus.instr_rvalid, bus.instr_rdata);
        end
        step();
    endtask

    task automatic test_data_write();
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b1;
        bus.data_be    = 4'hf;
        bus.data_addr  = 32'h24;
        bus.data_wdata = 32'hCAFE_F00D;
        @(negedge clk_sys);
        total++;
        if ({bus.data_gnt, bus.mem_req, bus.mem_we, bus.mem_be} !== 7'b111_1111 || bus.mem_addr !== 10'd9) begin
            bad++;
            $display("FAIL data_write_full got gnt=%b mem_req=%b we=%b be=%h addr=%0d required 1 1 1 f 9",
                     bus.data_gnt, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr);
        end
        expect_resp(1'b1, 1'b0, 32'h0);
        step();
        bus.data_be    = 4'b0011;
        bus.data_wdata = 32'h1234_5566;
        @(negedge clk_sys);
        total++;
        if ({bus.data_gnt, bus.mem_we, bus.mem_be} !== 6'b11_0011 || bus.mem_wdata !== 32'h1234_5566) begin
            bad++;
            $display("FAIL data_write_partial got gnt=%b we=%b be=%h wdata=%h required 1 1 3 12345566",
                     bus.data_gnt, bus.mem_we, bus.mem_be, bus.mem_wdata);
        end
        expect_resp(1'b1, 1'b0, 32'h0);
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        bus.instr_req  = 1'b1;
        bus.instr_addr = 32'h10;
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b0;
        bus.data_be    = 4'hf;
        bus.data_addr  = 32'h24;
        for (int i = 0; i < 6; i++) begin
            logic       want_i;
            logic [9:0] want_addr;
            want_i    = (i % 2 == 0);
            want_addr = want_i ? 10'd4 : 10'd9;
            @(negedge clk_sys);
            total++;
            if (bus.instr_gnt !== want_i || bus.data_gnt !== !want_i || bus.mem_req !== 1'b1 || bus.mem_addr !== want_addr) begin
                bad++;
                $display("FAIL rr_slot%0d got instr_gnt=%b data_gnt=%b mem_req=%b addr=%0d required %b %b 1 %0d",
                         i, bus.instr_gnt, bus.data_gnt, bus.mem_req, bus.mem_addr, want_i, !want_i, want_addr);
            end
            expect_resp(!want_i, 1'b0, want_i ? 32'hDEAD_BEEF : 32'hCAFE_5566);
            step();
        end
        idle();
        step();
    endtask

    task automatic test_out_of_range();
        bus.data_req  = 1'b1;
        bus.data_be   = 4'hf;
        bus.data_addr = 32'h0000_1000;
        @(negedge clk_sys);
        total++;
        if ({bus.data_gnt, bus.mem_req} !== 2'b10) begin
            bad++;
            $display("FAIL oor_data got gnt=%b mem_req=%b required 1 0", bus.data_gnt, bus.mem_req);
        end
        expect_resp(1'b1, 1'b1, 32'h0);
        step();
        bus.data_we    = 1'b1;
        bus.data_addr  = 32'h0000_0FFC;
        bus.data_wdata = 32'h55AA_55AA;
        @(negedge clk_sys);
        total++;
        if ({bus.data_gnt, bus.mem_req} !== 2'b11 || bus.mem_addr !== 10'h3FF) begin
            bad++;
            $display("FAIL last_word_write got gnt=%b mem_req=%b addr=%h required 1 1 3ff",
                     bus.data_gnt, bus.mem_req, bus.mem_addr);
        end
        expect_resp(1'b1, 1'b0, 32'h0);
        step();
        idle();
        bus.instr_req  = 1'b1;
        bus.instr_addr = 32'hFFFF_FFF0;
        @(negedge clk_sys);
        total++;
        if ({bus.instr_gnt, bus.mem_req} !== 2'b10) begin
            bad++;
            $display("FAIL oor_instr got gnt=%b mem_req=%b required 1 0", bus.instr_gnt, bus.mem_req);
        end
        expect_resp(1'b0, 1'b1, 32'h0);
        step();
        idle();
        bus.boot_req   = 1'b1;
        bus.boot_addr  = 32'h0000_2000;
        bus.boot_wdata = 32'h0F0F_0F0F;
        @(negedge clk_sys);
        total++;
        if ({bus.boot_gnt, bus.mem_req} !== 2'b10) begin
            bad++;
            $display("FAIL oor_boot got gnt=%b mem_req=%b required 1 0", bus.boot_gnt, bus.mem_req);
        end
        step();
        idle();
        bus.data_req  = 1'b1;
        bus.data_be   = 4'hf;
        bus.data_addr = 32'h0000_0FFC;
        @(negedge clk_sys);
        expect_resp(1'b1, 1'b0, 32'h55AA_55AA);
        step();
        idle();
        step();
    endtask

    task automatic test_reset_mid();
        bus.instr_req  = 1'b1;
        bus.instr_addr = 32'h10;
        @(negedge clk_sys);
        total++;
        if (bus.instr_gnt !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_grant got gnt=%b required 1", bus.instr_gnt);
        end
        rst_sys_n = 1'b0;
        @(negedge clk_sys);
        total++;
        if ({bus.instr_gnt, bus.instr_rvalid, bus.instr_err, bus.data_gnt, bus.data_rvalid, bus.mem_req} !== 6'h0 ||
            bus.instr_rdata !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_outputs got gnt=%b rvalid=%b err=%b mem_req=%b rdata=%h required all 0",
                     bus.instr_gnt, bus.instr_rvalid, bus.instr_err, bus.mem_req, bus.instr_rdata);
        end
        idle();
        #2 rst_sys_n = 1'b1;
        step();
        @(negedge clk_sys);
        total++;
        if (bus.instr_rvalid !== 1'b0 || bus.instr_rdata !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_dropped got rvalid=%b rdata=%h required 0 0", bus.instr_rvalid, bus.instr_rdata);
        end
        step();
    endtask

`ifdef RAM_ARB_PERF_EN
    task automatic test_perf();
        idle();
        perf_clr = 1'b1;
        step();
        perf_clr       = 1'b0;
        bus.boot_req   = 1'b1;
        bus.boot_addr  = 32'h20;
        bus.boot_wdata = 32'h0BAD_C0DE;
        bus.data_req   = 1'b1;
        bus.data_be    = 4'hf;
        bus.data_addr  = 32'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            total++;
            if (bus.data_gnt !== 1'b0 || bus.boot_gnt !== 1'b1) begin
                bad++;
                $display("FAIL perf_stall_cycle%0d got boot_gnt=%b data_gnt=%b required 1 0", i, bus.boot_gnt, bus.data_gnt);
            end
            step();
        end
        bus.boot_req = 1'b0;
        @(negedge clk_sys);
        expect_resp(1'b1, 1'b0, 32'h0BAD_C0DE);
        step();
        idle();
        @(negedge clk_sys);
        total++;
        if (perf_data_stall !== 16'd3 || perf_instr_stall !== 16'd0) begin
            bad++;
            $display("FAIL perf_count got data=%0d instr=%0d required 3 0", perf_data_stall, perf_instr_stall);
        end
        step();
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        @(negedge clk_sys);
        total++;
        if (perf_data_stall !== 16'd0) begin
            bad++;
            $display("FAIL perf_clear got data=%0d required 0", perf_data_stall);
        end
        step();
    endtask
`endif

    initial begin
        idle();
        bus.mem_rdata = 32'h0;
        test_reset();
        test_boot_priority();
        test_instr_read();
        test_data_write();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
`ifdef RAM_ARB_PERF_EN
        test_perf();
`endif
        step();
        step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_responses got %0d outstanding required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port instruction/data SRAM among three requesters: the Ibex instruction fetch port, the Ibex data port, and the UART bootloader write port.
- Sits between ibex_core/bus_mux/BootLoader and the SRAM macro. It replaces the ad-hoc port muxing currently inside the instruction ROM wrapper.
- Uses the Ibex req/gnt/rvalid protocol on the requester side. The memory side has fixed 1-cycle read latency.

Parameters:
- MEM_SIZE, 4096, SRAM size in bytes (power of two).
- AW, $clog2(MEM_SIZE/4), SRAM word-address width.
- ADDR_BASE, 32'h00000000, byte base address of the SRAM in the CPU map.

Ports:
- clk_sys  in  1  system clock
- rst_sys_n  in  1  asynchronous active-low reset
- boot_req  in  1  bootloader write request
- boot_addr  in  32  bootloader byte address
- boot_wdata  in  32  bootloader write word
- boot_gnt  out  1  bootloader request accepted
- instr_req  in  1  fetch request
- instr_addr  in  32  fetch byte address
- instr_gnt  out  1  fetch accepted
- instr_rvalid  out  1  fetch data valid
- instr_rdata  out  32  fetch data
- instr_err  out  1  fetch error
- data_req  in  1  data request
- data_we  in  1  data write enable
- data_be  in  4  data byte enables
- data_addr  in  32  data byte address
- data_wdata  in  32  data write word
- data_gnt  out  1  data accepted
- data_rvalid  out  1  data response valid
- data_rdata  out  32  data read word
- data_err  out  1  data error
- mem_req  out  1  SRAM access strobe
- mem_we  out  1  SRAM write
- mem_be  out  4  SRAM byte enables
- mem_addr  out  AW  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_req

Behaviour:
- Clock and reset: one clock, clk_sys. Reset rst_sys_n is asynchronous and active-low.
- Reset values: all gnt/rvalid/err outputs and mem_req are 0. Owner register is OWN_NONE. Round-robin pointer favours instr. Counters are 0.
- Grants per cycle: at most one requester is granted per cycle.
- Grant timing: gnt is combinational in the same cycle as req. mem_req is asserted in that same cycle with the winner's fields.
- Priority: boot has absolute priority over instr and data.
- Round-robin: instr vs data uses 2-way round-robin. After a grant to X, the pointer favours the other requester. If only one requests, it wins regardless of the pointer.
- Boot writes: always word writes (be = 4'hf). Boot gets no rvalid.
- Response routing: the registered owner tag routes the response in the cycle after the grant. instr_rvalid/data_rvalid pulse exactly 1 cycle after their gnt. Writes also return data_rvalid, with data_rdata = 0.
- Read data: rdata equals mem_rdata when valid and is held at its last value otherwise.
- Address range check: an address is in range when (addr - ADDR_BASE) < MEM_SIZE. An out-of-range request is still granted, but mem_req = 0. rvalid plus err = 1 follow next cycle, with rdata = 0. Out-of-range boot writes are silently dropped.
- Address mapping: mem_addr = (addr - ADDR_BASE)[AW+1:2]. Addresses wrap modulo MEM_SIZE only after passing the range check.
- Back-to-back: a new grant is allowed in the same cycle as the rvalid of the previous grant. There is no bubble, so 1 access per cycle is sustained.
- Simultaneous boot + CPU requests: boot wins, and the CPU gnt stays 0. The round-robin pointer does not advance.
- Reset mid-operation: rst_sys_n low clears the owner tag. Any pending rvalid is dropped.

Optional Feature:
- Macro: RAM_ARB_PERF_EN.
- With the macro defined:
  - Adds outputs perf_instr_stall[15:0] and perf_data_stall[15:0].
  - Each counts cycles where req = 1 and gnt = 0, saturating at 16'hFFFF.
  - Both counters clear when the extra input perf_clr is 1.
- Without the macro: the counters, perf_clr and the perf ports are absent.

Decomposition:
- Package ram_arb_pkg holds:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_INSTR, OWN_DATA, OWN_BOOT};
  - typedef struct mem_req_t {we, be, addr, wdata};
  - localparam PERF_W = 16.
- Sub-module rr_arb2: 2-input round-robin picker. Inputs req[1:0] and advance; outputs one-hot grant[1:0]; contains the pointer flop.

Test Plan:
- instr_req only, addr 0x10, mem_rdata 0xDEADBEEF next cycle → instr_gnt same cycle, mem_addr = 4, instr_rvalid = 1 and instr_rdata = 0xDEADBEEF one cycle later.
- instr_req and data_req held high for 6 cycles → grants alternate I,D,I,D,I,D; each rvalid lands 1 cycle after its gnt; no idle cycles.
- boot_req with data_req, boot_addr 0x20, wdata 0x12345678 → boot_gnt = 1, data_gnt = 0, mem_we = 1, mem_be = F, mem_addr = 8. Data is granted the next cycle.
- data read at 0x00001000 (MEM_SIZE = 4096) → data_gnt = 1, mem_req = 0, next cycle data_rvalid = 1, data_err = 1, data_rdata = 0.
- Grant instr, assert rst_sys_n low before the rvalid cycle → no instr_rvalid; all outputs 0 while in reset.
- With RAM_ARB_PERF_EN, boot_req held for 3 cycles with data_req → perf_data_stall = 3; perf_clr returns it to 0.
